// File: rtl/rv_isa_pkg.sv
// rv_isa_pkg: RV32I format codes, opcodes and immediate range limits shared by encoder and extender
package rv_isa_pkg;
    typedef enum logic [2:0] {
        FMT_I  = 3'd0,
        FMT_S  = 3'd1,
        FMT_B  = 3'd2,
        FMT_U  = 3'd3,
        FMT_J  = 3'd4,
        FMT_LI = 3'd5
    } fmt_e;
    localparam logic [6:0] OPC_LUI   = 7'b0110111;
    localparam logic [6:0] OPC_OPIMM = 7'b0010011;
    localparam int IMM12_MIN = -2048;
    localparam int IMM12_MAX = 2047;
    localparam int IMM13_MIN = -4096;
    localparam int IMM13_MAX = 4094;
    localparam int IMM21_MIN = -(1 << 20);
    localparam int IMM21_MAX = (1 << 20) - 2;
    function automatic logic in_range(input logic [31:0] v, input int lo, input int hi);
        return $signed(v) >= lo && $signed(v) <= hi;
    endfunction
endpackage

// File: rtl/imm_field_packer.sv
// imm_field_packer: combinational RV32I field packer with immediate range checking
// Ports: fmt/imm/opcode/funct3/rd/rs1/rs2 in; word = packed instruction, err = range or format error.
// Only I/S/B/U/J are packed here; any other fmt yields word=0, err=1.
module imm_field_packer
    import rv_isa_pkg::*;
(
    input  logic [2:0]  fmt,
    input  logic [31:0] imm,
    input  logic [6:0]  opcode,
    input  logic [2:0]  funct3,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    output logic [31:0] word,
    output logic        err
);
    always_comb begin
        word = fmt == FMT_I ? {imm[11:0], rs1, funct3, rd, opcode} :
               fmt == FMT_S ? {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode} :
               fmt == FMT_B ? {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode} :
               fmt == FMT_U ? {imm[31:12], rd, opcode} :
               fmt == FMT_J ? {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode} : 32'd0;
        err  = fmt == FMT_I ? !in_range(imm, IMM12_MIN, IMM12_MAX) :
               fmt == FMT_S ? !in_range(imm, IMM12_MIN, IMM12_MAX) :
               fmt == FMT_B ? !in_range(imm, IMM13_MIN, IMM13_MAX) || imm[0] :
               fmt == FMT_U ? imm[11:0] != 12'd0 :
               fmt == FMT_J ? !in_range(imm, IMM21_MIN, IMM21_MAX) || imm[0] : 1'b1;
    end
endmodule

// File: rtl/insn_encoder.sv
// insn_encoder: sequential RV32I instruction assembler with LI -> LUI+ADDI expansion
// Ports: clk, rst (async, active-high); request in_valid/in_ready with in_fmt, in_imm,
// in_opcode, in_funct3, in_rd, in_rs1, in_rs2; response out_valid/out_ready with
// out_insn and out_err (qualified by out_valid).
module insn_encoder
    import rv_isa_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  in_fmt,
    input  logic [31:0] in_imm,
    input  logic [6:0]  in_opcode,
    input  logic [2:0]  in_funct3,
    input  logic [4:0]  in_rd,
    input  logic [4:0]  in_rs1,
    input  logic [4:0]  in_rs2,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_insn,
    output logic        out_err
);
    typedef enum logic [1:0] {IDLE, OUT1, OUT2} state_e;
    state_e      state;
    logic        pending;
    logic [4:0]  p_rd;
    logic [11:0] p_lo;
    logic [19:0] hi;
    logic        li, two;
    logic [2:0]  pk_fmt, pk_f3;
    logic [31:0] pk_imm, pk_word;
    logic [6:0]  pk_op;
    logic [4:0]  pk_rs1;
    logic        pk_err;
    // LI is rewritten into a plain U (LUI) or I (ADDI x0) request so one packer serves all
    // formats; the ADDI that follows a LUI is built from the latched rd/lo.
    always_comb begin
        hi       = 20'((in_imm + 32'h800) >> 12);
        li       = in_fmt == FMT_LI;
        two      = li && hi != 20'd0;
        pk_fmt   = li ? (two ? 3'(FMT_U) : 3'(FMT_I)) : in_fmt;
        pk_imm   = two ? {hi, 12'd0} : li ? {{20{in_imm[11]}}, in_imm[11:0]} : in_imm;
        pk_op    = li ? (two ? OPC_LUI : OPC_OPIMM) : in_opcode;
        pk_f3    = li ? 3'd0 : in_funct3;
        pk_rs1   = li ? 5'd0 : in_rs1;
        in_ready = state == IDLE || (state == OUT1 && !pending && out_ready) || (state == OUT2 && out_ready);
    end
    imm_field_packer u_packer (
        .fmt(pk_fmt),
        .imm(pk_imm),
        .opcode(pk_op),
        .funct3(pk_f3),
        .rd(in_rd),
        .rs1(pk_rs1),
        .rs2(in_rs2),
        .word(pk_word),
        .err(pk_err)
    );
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            out_insn  <= 32'd0;
            out_err   <= 1'b0;
            pending   <= 1'b0;
            p_rd      <= 5'd0;
            p_lo      <= 12'd0;
        end else if (state == OUT1 && pending && out_ready) begin
            state    <= OUT2;
            out_insn <= {p_lo, p_rd, 3'b000, p_rd, OPC_OPIMM};
            out_err  <= 1'b0;
            pending  <= 1'b0;
        end else if (in_valid && in_ready) begin
            state     <= OUT1;
            out_valid <= 1'b1;
            out_insn  <= pk_word;
            out_err   <= pk_err;
            pending   <= two;
            p_rd      <= in_rd;
            p_lo      <= in_imm[11:0];
        end else if (out_valid && out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_insn_encoder.sv
// tb_insn_encoder: scoreboard bench for insn_encoder
module tb_insn_encoder;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_fmt;
    logic [31:0] in_imm;
    logic [6:0]  in_opcode;
    logic [2:0]  in_funct3;
    logic [4:0]  in_rd, in_rs1, in_rs2;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_insn;
    logic        out_err;
    logic        fixed_rdy = 1'b1;
    logic        rand_mode = 1'b0;
    logic        rnd_rdy = 1'b1;
    logic [32:0] exp_q[$];
    int          n_chk = 0;
    int          n_fail = 0;
    logic [2:0]  bf[18] = '{3'd0, 3'd0, 3'd0, 3'd0, 3'd1, 3'd1, 3'd2, 3'd2, 3'd2, 3'd2,
                            3'd3, 3'd3, 3'd4, 3'd4, 3'd4, 3'd4, 3'd6, 3'd7};
    int          bi[18] = '{2047, -2048, 2048, -2049, 2047, -2049, 4094, -4096, 4096, -4098,
                            32'hABCDE000, 32'hABCDE001, 1048574, -1048576, 1048576, 3, 5, 5};

    insn_encoder dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_fmt(in_fmt),
        .in_imm(in_imm), .in_opcode(in_opcode), .in_funct3(in_funct3), .in_rd(in_rd),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .out_valid(out_valid), .out_ready(out_ready),
        .out_insn(out_insn), .out_err(out_err)
    );

    always #5 clk = ~clk;
    assign out_ready = rand_mode ? rnd_rdy : fixed_rdy;
    always @(posedge clk) rnd_rdy <= 1'($urandom_range(0, 1));

    task automatic check(input string tag, input logic [32:0] got, input logic [32:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference encoding: {err, word} entries in emission order.
    task automatic push_exp(input logic [2:0] f, input logic [31:0] imm, input logic [6:0] op,
                            input logic [2:0] f3, input logic [4:0] rd, rs1, rs2);
        int s;
        logic [31:0] h;
        s = imm;
        case (f)
            3'd0: exp_q.push_back({s < -2048 || s > 2047, imm[11:0], rs1, f3, rd, op});
            3'd1: exp_q.push_back({s < -2048 || s > 2047, imm[11:5], rs2, rs1, f3, imm[4:0], op});
            3'd2: exp_q.push_back({s < -4096 || s > 4094 || imm[0], imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], op});
            3'd3: exp_q.push_back({imm[11:0] != 12'd0, imm[31:12], rd, op});
            3'd4: exp_q.push_back({s < -1048576 || s > 1048574 || imm[0], imm[20], imm[10:1], imm[11], imm[19:12], rd, op});
            3'd5: begin
                h = imm + 32'h800;
                if (h[31:12] != 20'd0) begin
                    exp_q.push_back({1'b0, h[31:12], rd, 7'h37});
                    exp_q.push_back({1'b0, imm[11:0], rd, 3'b000, rd, 7'h13});
                end else
                    exp_q.push_back({1'b0, imm[11:0], 5'd0, 3'b000, rd, 7'h13});
            end
            default: exp_q.push_back({1'b1, 32'd0});
        endcase
    endtask

    task automatic send(input logic [2:0] f, input logic [31:0] imm, input logic [6:0] op,
                        input logic [2:0] f3, input logic [4:0] rd, rs1, rs2);
        int cnt;
        push_exp(f, imm, op, f3, rd, rs1, rs2);
        in_valid = 1'b1; in_fmt = f; in_imm = imm; in_opcode = op;
        in_funct3 = f3; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
        @(negedge clk);
        cnt = 0;
        while (!in_ready && cnt < 100) begin
            @(negedge clk);
            cnt++;
        end
        if (!in_ready) check("accept_timeout", {32'd0, in_ready}, 33'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_imm = $urandom;
        in_rd = 5'($urandom);
    endtask

    always @(negedge clk)
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) check("spurious_out", {32'd0, out_valid}, 33'd0);
            else check("out_word", {out_err, out_insn}, exp_q.pop_front());
        end

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_fmt = 3'd0; in_imm = 32'd0; in_opcode = 7'd0;
        in_funct3 = 3'd0; in_rd = 5'd0; in_rs1 = 5'd0; in_rs2 = 5'd0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", {32'd0, out_valid}, 33'd0);
        check("rst_word", {out_err, out_insn}, 33'd0);
        check("rst_ready", {32'd0, in_ready}, 33'd1);
        rst = 1'b0;
        send(3'd0, 32'd5, 7'h13, 3'd0, 5'd1, 5'd0, 5'd0);
        check("i_lat_valid", {32'd0, out_valid}, 33'd1);
        check("i_word", {out_err, out_insn}, {1'b0, 32'h00500093});
        send(3'd5, 32'h12345678, 7'h00, 3'd7, 5'd5, 5'd9, 5'd9);
        check("li_lui", {out_err, out_insn}, {1'b0, 32'h123452B7});
        @(posedge clk);
        #1;
        check("li_addi", {out_err, out_insn}, {1'b0, 32'h67828293});
        @(posedge clk);
        #1;
        send(3'd5, 32'hFFFFF800, 7'h00, 3'd0, 5'd1, 5'd0, 5'd0);
        check("li_wrap", {out_err, out_insn}, {1'b0, 32'h80000093});
        check("li_wrap_ready", {32'd0, in_ready}, 33'd1);
        @(posedge clk);
        #1;
        check("li_wrap_single", {32'd0, out_valid}, 33'd0);
        send(3'd2, 32'd8, 7'h63, 3'd0, 5'd0, 5'd1, 5'd2);
        check("b_word", {out_err, out_insn}, {1'b0, 32'h00208463});
        send(3'd2, 32'd7, 7'h63, 3'd0, 5'd0, 5'd1, 5'd2);
        check("b_odd_err", {32'd0, out_err}, 33'd1);
        for (int i = 0; i < 18; i++) send(bf[i], bi[i], 7'h23, 3'd2, 5'd7, 5'd9, 5'd11);
        @(posedge clk);
        #1;
        fixed_rdy = 1'b0;
        send(3'd0, 32'd100, 7'h13, 3'd0, 5'd3, 5'd2, 5'd0);
        repeat (3) begin
            @(negedge clk);
            check("bp_word", {out_err, out_insn}, {1'b0, 32'h06410193});
            check("bp_ready", {31'd0, out_valid, in_ready}, 33'd2);
        end
        @(posedge clk);
        #1;
        fixed_rdy = 1'b1;
        send(3'd0, 32'hFFFFFFFF, 7'h13, 3'd0, 5'd4, 5'd0, 5'd0);
        check("b2b_word", {out_valid, out_insn}, {1'b1, 32'hFFF00213});
        @(posedge clk);
        #1;
        fixed_rdy = 1'b0;
        send(3'd5, 32'h12345678, 7'h00, 3'd0, 5'd5, 5'd0, 5'd0);
        fixed_rdy = 1'b1;
        @(posedge clk);
        #1;
        fixed_rdy = 1'b0;
        check("out2_word", {out_err, out_insn}, {1'b0, 32'h67828293});
        #2 rst = 1'b1;
        #1;
        check("mid_rst_valid", {32'd0, out_valid}, 33'd0);
        check("mid_rst_word", {out_err, out_insn}, 33'd0);
        check("mid_rst_ready", {32'd0, in_ready}, 33'd1);
        exp_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        fixed_rdy = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("post_rst_idle", {32'd0, out_valid}, 33'd0);
        end
        @(posedge clk);
        #1;
        send(3'd0, 32'd5, 7'h13, 3'd0, 5'd1, 5'd0, 5'd0);
        check("post_rst_word", {out_err, out_insn}, {1'b0, 32'h00500093});
        rand_mode = 1'b1;
        for (int i = 0; i < 40; i++)
            send(3'($urandom_range(0, 7)),
                 $urandom_range(0, 1) ? $urandom : $urandom_range(0, 8191) - 32'd4096,
                 7'($urandom), 3'($urandom), 5'($urandom), 5'($urandom), 5'($urandom));
        rand_mode = 1'b0;
        for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(posedge clk);
        repeat (2) @(posedge clk);
        check("drain", 33'(exp_q.size()), 33'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
